// File: rtl/acia_uart.sv
// acia_uart: 6502-bus UART responder with a fixed 8N1 frame format.
// It has a register file with STATUS, DATA and CTRL, a TX holding register
// feeding a shift register, and an RX path with a double-flop synchroniser.
// The level interrupt request is driven from the RX-full and TX-empty flags.
module acia_uart #(
  parameter int CLK_DIV = 104
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cs,
  input  logic       we,
  input  logic [1:0] addr,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       irq,
  input  logic       RX,
  output logic       TX
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLK_DIV / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  // bus decode
  logic rd_en;
  logic rd_data;
  logic wr_data;
  logic wr_ctrl;

  assign rd_en   = cs & ~we;
  assign rd_data = rd_en & (addr == 2'd1);
  assign wr_data = cs & we & (addr == 2'd1);
  assign wr_ctrl = cs & we & (addr == 2'd2);

  // control state
  tx_state_t        tx_state, tx_state_d;
  rx_state_t        rx_state, rx_state_d;
  logic [CNT_W-1:0] tx_cnt, rx_cnt;
  logic [2:0]       tx_bit, rx_bit;
  logic             txe, txe_d;
  logic             rxf, rxf_d;
  logic             ovr, ovr_d;
  logic             fe, fe_d;
  logic             rxie, rxie_d;
  logic             txie, txie_d;
  logic             irq_d;
  logic             tx_d;
  logic             tx_load;
  logic             tx_shift_en;
  logic             tx_cnt_end;
  logic             wr_accept;
  logic             rx_meta, rx_sync, rx_prev;
  logic             rx_falling;
  logic             rx_sample;
  logic             rx_done;
  logic             rx_cnt_end;
  logic [7:0]       rd_mux;

  // datapath (not reset)
  logic [7:0] tx_hold;
  logic [7:0] tx_shift;
  logic [7:0] rx_shift;
  logic [7:0] rx_data;

  assign tx_cnt_end = (tx_cnt == CNT_LAST);
  assign rx_cnt_end = (rx_cnt == CNT_LAST);
  assign rx_falling = rx_prev & ~rx_sync;

  // TX next-state, shifter control and next serial line level
  always_comb begin
    tx_state_d  = tx_state;
    tx_load     = 1'b0;
    tx_shift_en = 1'b0;
    tx_d        = 1'b1;
    case (tx_state)
      TX_IDLE: begin
        if (!txe) begin
          tx_load    = 1'b1;
          tx_state_d = TX_START;
        end
      end
      TX_START: begin
        if (tx_cnt_end) tx_state_d = TX_DATA;
      end
      TX_DATA: begin
        if (tx_cnt_end) begin
          tx_shift_en = 1'b1;
          if (tx_bit == 3'd7) tx_state_d = TX_STOP;
        end
      end
      TX_STOP: begin
        if (tx_cnt_end) begin
          if (!txe) begin
            tx_load    = 1'b1;
            tx_state_d = TX_START;
          end else begin
            tx_state_d = TX_IDLE;
          end
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
    case (tx_state_d)
      TX_START: tx_d = 1'b0;
      TX_DATA:  tx_d = tx_shift_en ? tx_shift[1] : tx_shift[0];
      default:  tx_d = 1'b1;
    endcase
  end

  // RX next-state: start validation at half bit, then whole-bit mid samples
  always_comb begin
    rx_state_d = rx_state;
    rx_sample  = 1'b0;
    rx_done    = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        if (rx_falling) rx_state_d = RX_START;
      end
      RX_START: begin
        if (rx_cnt == CNT_HALF) rx_state_d = rx_sync ? RX_IDLE : RX_DATA;
      end
      RX_DATA: begin
        if (rx_cnt_end) begin
          rx_sample = 1'b1;
          if (rx_bit == 3'd7) rx_state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (rx_cnt_end) begin
          rx_done    = 1'b1;
          rx_state_d = RX_IDLE;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // Status flags, control bits and interrupt; a read racing an RX completion keeps RXF set
  always_comb begin
    wr_accept = wr_data & (txe | tx_load);
    txe_d     = txe;
    if (tx_load)   txe_d = 1'b1;
    if (wr_accept) txe_d = 1'b0;
    rxf_d = rxf;
    ovr_d = ovr;
    fe_d  = fe;
    if (rd_data) begin
      rxf_d = 1'b0;
      ovr_d = 1'b0;
      fe_d  = 1'b0;
    end
    if (rx_done) begin
      rxf_d = 1'b1;
      fe_d  = ~rx_sync;
      if (rxf && !rd_data) ovr_d = 1'b1;
    end
    rxie_d = wr_ctrl ? din[0] : rxie;
    txie_d = wr_ctrl ? din[1] : txie;
    irq_d  = (rxie_d & rxf_d) | (txie_d & txe_d);
  end

  // Register read mux (values as they stand before the access edge)
  always_comb begin
    rd_mux = 8'h00;
    case (addr)
      2'd0:    rd_mux = {irq, 2'b00, (tx_state != TX_IDLE), fe, ovr, txe, rxf};
      2'd1:    rd_mux = rx_data;
      2'd2:    rd_mux = {6'b000000, txie, rxie};
      default: rd_mux = 8'h00;
    endcase
  end

  // FSM state registers, counters, flags and bus read port
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state <= TX_IDLE;
      rx_state <= RX_IDLE;
      tx_cnt   <= '0;
      rx_cnt   <= '0;
      tx_bit   <= 3'd0;
      rx_bit   <= 3'd0;
      txe      <= 1'b1;
      rxf      <= 1'b0;
      ovr      <= 1'b0;
      fe       <= 1'b0;
      rxie     <= 1'b0;
      txie     <= 1'b0;
      irq      <= 1'b0;
      TX       <= 1'b1;
      dout     <= 8'h00;
      rx_meta  <= 1'b1;
      rx_sync  <= 1'b1;
      rx_prev  <= 1'b1;
    end else begin
      tx_state <= tx_state_d;
      rx_state <= rx_state_d;
      if (tx_state == TX_IDLE || tx_state_d != tx_state || tx_cnt_end) tx_cnt <= '0;
      else tx_cnt <= tx_cnt + CNT_ONE;
      if (rx_state == RX_IDLE || rx_state_d != rx_state || rx_cnt_end) rx_cnt <= '0;
      else rx_cnt <= rx_cnt + CNT_ONE;
      if (tx_state == TX_START) tx_bit <= 3'd0;
      else if (tx_shift_en) tx_bit <= tx_bit + 3'd1;
      if (rx_state == RX_START) rx_bit <= 3'd0;
      else if (rx_sample) rx_bit <= rx_bit + 3'd1;
      txe     <= txe_d;
      rxf     <= rxf_d;
      ovr     <= ovr_d;
      fe      <= fe_d;
      rxie    <= rxie_d;
      txie    <= txie_d;
      irq     <= irq_d;
      TX      <= tx_d;
      if (rd_en) dout <= rd_mux;
      rx_meta <= RX;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  // Data registers: holding register, TX shifter, RX shifter and received byte
  always_ff @(posedge clk) begin
    if (wr_accept) tx_hold <= din;
    if (tx_load) tx_shift <= tx_hold;
    else if (tx_shift_en) tx_shift <= {1'b1, tx_shift[7:1]};
    if (rx_sample) rx_shift <= {rx_sync, rx_shift[7:1]};
    if (rx_done) rx_data <= rx_shift;
  end

endmodule

// File: tb/tb_acia_uart.sv
// tb_acia_uart: scoreboard bench for acia_uart with CLK_DIV=16.
// Bus reads and TX frames queue their expected values when issued.
// Separate monitors pop and compare those values when the DUT responds.
module tb_acia_uart;

  localparam int DIV = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cs = 1'b0;
  logic       we = 1'b0;
  logic [1:0] addr = 2'd0;
  logic [7:0] din = 8'h00;
  logic [7:0] dout;
  logic       irq;
  logic       RX = 1'b1;
  logic       TX;

  int n_tests = 0;
  int n_fail  = 0;
  logic tx_mon_en = 1'b1;

  logic [7:0] rd_exp_q[$];
  string      rd_name_q[$];
  logic [7:0] tx_exp_q[$];

  acia_uart #(.CLK_DIV(DIV)) dut (
    .clk  (clk),
    .reset(reset),
    .cs   (cs),
    .we   (we),
    .addr (addr),
    .din  (din),
    .dout (dout),
    .irq  (irq),
    .RX   (RX),
    .TX   (TX)
  );

  always #5 clk = ~clk;

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check8(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h", nm, act, exp);
    end
  endtask

  task automatic check_int(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Read-data monitor: every read accepted at an edge is compared just after it
  always @(posedge clk) begin
    if (cs && !we && !reset) begin
      #1;
      if (rd_exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL rd_unexpected: got %02h with no expected value queued", dout);
      end else begin
        check8(rd_name_q.pop_front(), dout, rd_exp_q.pop_front());
      end
    end
  end

  // TX frame monitor: decode each frame at bit centres and compare with the queue
  initial begin : tx_mon
    logic [7:0] b;
    logic [7:0] e;
    logic       st;
    logic       sp;
    forever begin
      @(negedge TX);
      if (tx_mon_en) begin
        repeat (DIV/2) @(posedge clk);
        #1 st = TX;
        for (int i = 0; i < 8; i++) begin
          repeat (DIV) @(posedge clk);
          #1 b[i] = TX;
        end
        repeat (DIV) @(posedge clk);
        #1 sp = TX;
        n_tests++;
        if (tx_exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL tx_frame: got byte %02h with no expected frame queued", b);
        end else begin
          e = tx_exp_q.pop_front();
          if (st !== 1'b0 || sp !== 1'b1 || b !== e) begin
            n_fail++;
            $display("FAIL tx_frame: got start=%b data=%02h stop=%b expected start=0 data=%02h stop=1",
                     st, b, sp, e);
          end
        end
      end
    end
  end

  // Bus helpers: called at a falling edge, return at the next falling edge
  task automatic bus(input logic w, input logic [1:0] a, input logic [7:0] d);
    cs = 1'b1; we = w; addr = a; din = d;
    @(negedge clk);
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    if (a == 2'd1) tx_exp_q.push_back(d);
    bus(1'b1, a, d);
  endtask

  task automatic wr_raw(input logic [1:0] a, input logic [7:0] d);
    bus(1'b1, a, d);
  endtask

  task automatic rd(input logic [1:0] a, input logic [7:0] exp, input string nm);
    rd_exp_q.push_back(exp);
    rd_name_q.push_back(nm);
    bus(1'b0, a, 8'h00);
  endtask

  task automatic idle();
    cs = 1'b0; we = 1'b0; addr = 2'd0; din = 8'h00;
  endtask

  task automatic ncyc(input int n);
    idle();
    repeat (n) @(negedge clk);
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stopbit);
    RX = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      repeat (DIV) @(negedge clk);
    end
    RX = stopbit;
    repeat (DIV) @(negedge clk);
    RX = 1'b1;
  endtask

  // Expected TX level k edges after the write of two back-to-back bytes
  function automatic logic tx_expect(input int k, input logic [7:0] b0, input logic [7:0] b1);
    int j;
    logic [7:0] b;
    if (k < 1 || k > 20 * DIV) return 1'b1;
    j = (k - 1) % (10 * DIV);
    b = (k <= 10 * DIV) ? b0 : b1;
    if (j < DIV) return 1'b0;
    if (j < 9 * DIV) return b[(j - DIV) / DIV];
    return 1'b1;
  endfunction

  initial begin : main
    int errs;
    int rise;

    // 1: reset state and register access basics
    repeat (3) @(posedge clk);
    #1;
    check8("reset_tx", {7'd0, TX}, 8'h01);
    check8("reset_irq", {7'd0, irq}, 8'h00);
    @(negedge clk);
    reset = 1'b0;
    rd(2'd0, 8'h02, "reset_status");
    rd(2'd2, 8'h00, "reset_ctrl");
    wr_raw(2'd0, 8'hFF);
    wr_raw(2'd3, 8'hFF);
    wr(2'd2, 8'hFF);
    rd(2'd2, 8'h03, "ctrl_rw");
    rd(2'd3, 8'h00, "reserved_read");
    rd(0, 8'h82, "status_txie_irq");
    wr(2'd2, 8'h00);
    rd(0, 8'h02, "status_irq_off");
    ncyc(4);

    // 2: transmit A5 then 3C back to back
    wr(2'd1, 8'hA5);
    errs = 0;
    fork
      begin
        for (int k = 1; k <= 21 * DIV; k++) begin
          @(posedge clk);
          #1;
          if (TX !== tx_expect(k, 8'hA5, 8'h3C)) errs++;
        end
      end
      begin
        rd(2'd0, 8'h00, "tx_status_write_edge");
        rd(2'd0, 8'h12, "tx_status_txe_back");
        wr(2'd1, 8'h3C);
        rd(2'd0, 8'h10, "tx_status_holding_full");
        idle();
      end
    join
    check_int("tx_waveform_errors", errs, 0);
    ncyc(4);

    // 3: single RX frame
    send_rx(8'h5A, 1'b1);
    ncyc(4);
    rd(2'd0, 8'h03, "rx_status_full");
    rd(2'd1, 8'h5A, "rx_data");
    rd(2'd0, 8'h02, "rx_status_cleared");
    ncyc(4);

    // 4: overrun
    send_rx(8'h11, 1'b1);
    send_rx(8'h22, 1'b1);
    ncyc(4);
    rd(2'd0, 8'h07, "ovr_status");
    rd(2'd1, 8'h22, "ovr_data");
    rd(2'd0, 8'h02, "ovr_cleared");
    ncyc(4);

    // 5: framing error with RX interrupt, then glitch rejection
    wr(2'd2, 8'h01);
    idle();
    rise = 0;
    fork
      send_rx(8'hC3, 1'b0);
      begin
        repeat (9 * DIV) @(negedge clk);
        for (int c = 1; c <= DIV; c++) begin
          @(posedge clk);
          #1;
          if (irq && rise == 0) rise = c;
        end
      end
    join
    n_tests++;
    if (rise < DIV/2 || rise > DIV/2 + 5) begin
      n_fail++;
      $display("FAIL fe_irq_rise: got irq at stop-bit cycle %0d, required cycle %0d..%0d",
               rise, DIV/2, DIV/2 + 5);
    end
    ncyc(2);
    rd(2'd0, 8'h8B, "fe_status");
    rd(2'd1, 8'hC3, "fe_data");
    idle();
    #1;
    check8("fe_irq_cleared", {7'd0, irq}, 8'h00);
    @(negedge clk);
    rd(2'd0, 8'h02, "fe_status_cleared");
    wr(2'd2, 8'h00);
    idle();
    RX = 1'b0;
    repeat (8) @(negedge clk);
    RX = 1'b1;
    ncyc(12 * DIV);
    rd(2'd0, 8'h02, "glitch_no_byte");
    ncyc(4);

    // 6: reset during transmission of FF
    wr(2'd2, 8'h03);
    tx_mon_en = 1'b0;
    wr_raw(2'd1, 8'hFF);
    ncyc(6);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check8("abort_tx_high", {7'd0, TX}, 8'h01);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check8("abort_irq", {7'd0, irq}, 8'h00);
    @(negedge clk);
    rd(2'd0, 8'h02, "abort_status");
    rd(2'd2, 8'h00, "abort_ctrl");
    idle();
    errs = 0;
    for (int k = 0; k < 12 * DIV; k++) begin
      @(posedge clk);
      #1;
      if (TX !== 1'b1) errs++;
    end
    check_int("abort_no_residual_bits", errs, 0);
    @(negedge clk);
    check_int("rd_queue_drained", rd_exp_q.size(), 0);
    check_int("tx_queue_drained", tx_exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
